minmax_scan_ctrl: RTL

Sequencing controller that streams a block of signed 16-bit operands through the shared combinational lessThan comparator and reports the running minimum and maximum. One comparator is time-multiplexed for both the min test and the max test, so each element after the first takes three cycles. The block sits beside the ALU compare path and drives the comparator's InA/InB. It samples the comparator's Out in the same cycle.

---
 rtl/minmax_scan_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/minmax_scan_ctrl.sv
// Streams a block of signed operands through one shared lessThan comparator and
// tracks the running min/max. Define MINMAX_IDX_EN to add min_idx/max_idx outputs.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; results hold their last values
// S_ACCEPT  | in_ready=1, waiting for the next element handshake
// S_CMP_MIN | comparator asks cur < min_out
// S_CMP_MAX | comparator asks max_out < cur
// S_DONE    | one-cycle done pulse, results final
module minmax_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] min_out,
`ifdef MINMAX_IDX_EN
    output logic [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx
`else
    output logic [WIDTH-1:0] max_out
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCEPT  = 3'd1,
        S_CMP_MIN = 3'd2,
        S_CMP_MAX = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
`ifdef MINMAX_IDX_EN
    logic [CNT_W-1:0] min_idx_q, min_idx_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d;
`endif

    logic hs;

    assign hs = in_valid && (state_q == S_ACCEPT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? S_ACCEPT : S_DONE;
                end
            end
            S_ACCEPT: begin
                if (hs) begin
                    if (cnt_q == '0) begin
                        state_d = (len_q == CNT_W'(1)) ? S_DONE : S_ACCEPT;
                    end else begin
                        state_d = S_CMP_MIN;
                    end
                end
            end
            S_CMP_MIN: state_d = S_CMP_MAX;
            S_CMP_MAX: state_d = (cnt_q == len_q) ? S_DONE : S_ACCEPT;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        cmp_a    = '0;
        cmp_b    = '0;
        case (state_q)
            S_IDLE:   busy = 1'b0;
            S_ACCEPT: in_ready = 1'b1;
            S_CMP_MIN: begin
                cmp_a = cur_q;
                cmp_b = min_q;
            end
            S_CMP_MAX: begin
                cmp_a = max_q;
                cmp_b = cur_q;
            end
            S_DONE:   done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    // Datapath next values; min/max only change on a first-element load,
    // a winning compare, or a zero-length scan.
    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        cur_d = cur_q;
        min_d = min_q;
        max_d = max_q;
`ifdef MINMAX_IDX_EN
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d = len;
                        cnt_d = '0;
                    end else begin
                        min_d = '0;
                        max_d = '0;
`ifdef MINMAX_IDX_EN
                        min_idx_d = '0;
                        max_idx_d = '0;
`endif
                    end
                end
            end
            S_ACCEPT: begin
                if (hs) begin
                    cur_d = in_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        min_d = in_data;
                        max_d = in_data;
`ifdef MINMAX_IDX_EN
                        min_idx_d = '0;
                        max_idx_d = '0;
`endif
                    end
                end
            end
            S_CMP_MIN: begin
                if (cmp_lt) begin
                    min_d = cur_q;
`ifdef MINMAX_IDX_EN
                    min_idx_d = cnt_q - CNT_W'(1);
`endif
                end
            end
            S_CMP_MAX: begin
                if (cmp_lt) begin
                    max_d = cur_q;
`ifdef MINMAX_IDX_EN
                    max_idx_d = cnt_q - CNT_W'(1);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt_q <= '0;
            cur_q <= '0;
            min_q <= '0;
            max_q <= '0;
`ifdef MINMAX_IDX_EN
            min_idx_q <= '0;
            max_idx_q <= '0;
`endif
        end else begin
            len_q <= len_d;
            cnt_q <= cnt_d;
            cur_q <= cur_d;
            min_q <= min_d;
            max_q <= max_d;
`ifdef MINMAX_IDX_EN
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
`endif
        end
    end

    assign min_out = min_q;
    assign max_out = max_q;
`ifdef MINMAX_IDX_EN
    assign min_idx = min_idx_q;
    assign max_idx = max_idx_q;
`endif

endmodule
